// File: rtl/keyunit.sv
// keyunit: board push-button / slide-switch front end.
// Synchronises and debounces two active-low keys and ten switches, then
// turns KEY0/KEY1 presses into increments/decrements of the hex digit of
// `value` selected by switches[1:0], with hold-to-auto-repeat.
// Pressing both keys restores INIT_VALUE.
// Optional build macro KEYUNIT_WRAP_EN: steps wrap modulo 2^16 instead of
// saturating at 16'h0000 / 16'hFFFF.
module keyunit #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000,
    parameter logic [15:0] INIT_VALUE      = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  keys_n,
    input  logic [9:0]  switches,
    output logic [9:0]  switches_db,
    output logic [15:0] value,
    output logic        value_upd,
    output logic [1:0]  digit_sel
);

    localparam int NIN  = 12;  // [1:0] keys, [11:2] switches
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TM_W = $clog2(TMAX + 1);

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] HOLD_LAST = TM_W'(HOLD_CYCLES - 1);
    localparam logic [TM_W-1:0] REP_LAST  = TM_W'(REPEAT_CYCLES - 1);

    // Raw keys idle high (released), switches idle low.
    localparam logic [NIN-1:0] SYNC_RST = {10'b0, 2'b11};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HOLD = 2'd1,
        REPEAT    = 2'd2,
        LOCKED    = 2'd3
    } state_t;

    logic [NIN-1:0]  sync1, sync2;
    logic [NIN-1:0]  sync_lvl;
    logic [NIN-1:0]  db_q;
    logic [DB_W-1:0] db_cnt [NIN];

    logic [1:0]      keys_db, keys_prev;
    logic            inc_rise, dec_rise, both_pressed;

    state_t          state, state_nxt;
    logic [TM_W-1:0] timer, timer_nxt;
    logic [15:0]     value_nxt;
    logic            active_dec, active_nxt;
    logic            do_step, step_dec;

    logic [3:0]      shamt;
    logic [15:0]     step16;
    logic [15:0]     inc_res, dec_res;

    // Two-flop synchroniser for every raw input.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge value of its source; blocking here would collapse the two stages into one.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= SYNC_RST;
            sync2 <= SYNC_RST;
        end else begin
            sync1 <= {switches, keys_n};
            sync2 <= sync1;
        end
    end

    // Keys become active-high (pressed = 1) after synchronisation.
    assign sync_lvl = {sync2[NIN-1:2], ~sync2[1:0]};

    // Per-input debounce: accept a new level only after it has differed
    // from the debounced state for DEBOUNCE_CYCLES consecutive cycles.
    // NOTE: the counter array is reset explicitly; these are control registers whose stale contents would shorten the first debounce after reset, not a data RAM that could be left uninitialised.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_q <= '0;
            for (int i = 0; i < NIN; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (sync_lvl[i] == db_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_q[i]   <= sync_lvl[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign keys_db     = db_q[1:0];
    assign switches_db = db_q[NIN-1:2];
    assign digit_sel   = switches_db[1:0];

    assign inc_rise     = keys_db[0] & ~keys_prev[0];
    assign dec_rise     = keys_db[1] & ~keys_prev[1];
    assign both_pressed = keys_db[0] & keys_db[1];

    // Step of one unit in the selected hex digit.
    assign shamt  = {digit_sel, 2'b00};
    assign step16 = 16'h0001 << shamt;

`ifdef KEYUNIT_WRAP_EN
    // Wrap modulo 2^16.
    assign inc_res = value + step16;
    assign dec_res = value - step16;
`else
    logic [16:0] sum17, diff17;

    // 17-bit arithmetic; the carry/borrow bit selects the clamp.
    always_comb begin
        sum17   = {1'b0, value} + {1'b0, step16};
        diff17  = {1'b0, value} - {1'b0, step16};
        inc_res = sum17[16]  ? 16'hFFFF : sum17[15:0];
        dec_res = diff17[16] ? 16'h0000 : diff17[15:0];
    end
`endif

    // Key FSM: next state, hold/repeat timer and next value.
    // NOTE: every output of this block gets a default first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        active_nxt = active_dec;
        value_nxt  = value;
        do_step    = 1'b0;
        step_dec   = active_dec;

        if (state != LOCKED && both_pressed) begin
            // Both keys override any step that would be due this cycle.
            value_nxt = INIT_VALUE;
            timer_nxt = '0;
            state_nxt = LOCKED;
        end else begin
            unique case (state)
                IDLE: begin
                    if (inc_rise || dec_rise) begin
                        do_step    = 1'b1;
                        step_dec   = dec_rise;
                        active_nxt = dec_rise;
                        timer_nxt  = '0;
                        state_nxt  = WAIT_HOLD;
                    end
                end
                WAIT_HOLD: begin
                    if (!keys_db[active_dec]) begin
                        timer_nxt = '0;
                        state_nxt = IDLE;
                    end else if (timer == HOLD_LAST) begin
                        do_step   = 1'b1;
                        timer_nxt = '0;
                        state_nxt = REPEAT;
                    end else begin
                        timer_nxt = timer + TM_W'(1);
                    end
                end
                REPEAT: begin
                    if (!keys_db[active_dec]) begin
                        timer_nxt = '0;
                        state_nxt = IDLE;
                    end else if (timer == REP_LAST) begin
                        do_step   = 1'b1;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TM_W'(1);
                    end
                end
                LOCKED: begin
                    if (!keys_db[0] && !keys_db[1]) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end

        if (do_step) value_nxt = step_dec ? dec_res : inc_res;
    end

    // FSM and value registers; value_upd flags a real change of value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            active_dec <= 1'b0;
            keys_prev  <= 2'b00;
            value      <= INIT_VALUE;
            value_upd  <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            active_dec <= active_nxt;
            keys_prev  <= keys_db;
            value      <= value_nxt;
            value_upd  <= (value_nxt != value);
        end
    end

endmodule

// File: tb/tb_keyunit.sv
// Testbench for keyunit: directed key/switch sequences. Expected value
// updates (value and cycle) are queued as stimulus is issued; a monitor
// pops and compares on every value_upd strobe, and any strobe with an
// empty queue is an error.
module tb_keyunit;

    localparam int          DB   = 4;
    localparam int          HOLD = 20;
    localparam int          REP  = 5;
    localparam logic [15:0] INIT = 16'h0100;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  keys_n;
    logic [9:0]  switches;
    logic [9:0]  switches_db;
    logic [15:0] value;
    logic        value_upd;
    logic [1:0]  digit_sel;

    keyunit #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP),
        .INIT_VALUE     (INIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .keys_n     (keys_n),
        .switches   (switches),
        .switches_db(switches_db),
        .value      (value),
        .value_upd  (value_upd),
        .digit_sel  (digit_sel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] value;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push(input logic [15:0] v, input int c);
        exp_t e;
        e.value = v;
        e.cyc   = c;
        sb.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
    endtask

    task automatic press(input int key, input int n_low);
        keys_n[key] = 1'b0;
        wait_cycles(n_low);
        keys_n[key] = 1'b1;
    endtask

    // Monitor: every strobe must match the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (value_upd === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_upd: value=0x%0h at cycle %0d, no update expected", value, cyc);
            end else begin
                e = sb.pop_front();
                check("upd_value", {16'h0, value}, {16'h0, e.value});
                check("upd_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          c;
        logic [15:0] v;

        reset    = 1'b1;
        keys_n   = 2'b11;
        switches = '0;
        wait_cycles(3);

        // Reset state.
        check("rst_value",       value,       INIT);
        check("rst_value_upd",   value_upd,   0);
        check("rst_switches_db", switches_db, 0);
        check("rst_digit_sel",   digit_sel,   0);
        reset = 1'b0;
        wait_cycles(10);

        // 1: single clean press of KEY0, digit 0.
        c = cyc;
        push(16'h0101, c + 7);
        press(0, 10);
        wait_cycles(20);
        check("t1_value", value, 16'h0101);

        // 2: glitchy press never debounces.
        do_reset();
        wait_cycles(5);
        keys_n[0] = 1'b0; wait_cycles(3);
        keys_n[0] = 1'b1; wait_cycles(1);
        keys_n[0] = 1'b0; wait_cycles(3);
        keys_n[0] = 1'b1;
        wait_cycles(20);
        check("t2_value", value, INIT);

        // 3: hold KEY1 on digit 2: press, hold step, then repeats.
        do_reset();
        switches = 10'd2;
        wait_cycles(10);
        check("t3_digit_sel", digit_sel, 2);
        c = cyc;
        v = INIT;
        for (int i = 0; i < 9; i++) begin
            v = v - 16'h0100;
`ifdef KEYUNIT_WRAP_EN
            push(v, (i == 0) ? c + 7 : c + 27 + REP * (i - 1));
`else
            if (i == 0) push(v, c + 7);
`endif
        end
        keys_n[1] = 1'b0;
        wait_cycles(60);
        keys_n[1] = 1'b1;
        wait_cycles(20);
`ifdef KEYUNIT_WRAP_EN
        check("t3_value", value, 16'hF800);
`else
        check("t3_value", value, 16'h0000);
`endif

        // 4: digit 3 presses up to 0xF100, then one more hits the top.
        do_reset();
        switches = 10'd3;
        wait_cycles(10);
        v = INIT;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                check("t4_pre_value", value, 16'hF100);
`ifdef KEYUNIT_WRAP_EN
                v = 16'h0100;
`else
                v = 16'hFFFF;
`endif
            end else begin
                v = v + 16'h1000;
            end
            c = cyc;
            push(v, c + 7);
            press(0, 10);
            wait_cycles(10);
        end
`ifdef KEYUNIT_WRAP_EN
        check("t4_value", value, 16'h0100);
`else
        check("t4_value", value, 16'hFFFF);
`endif

        // 5: KEY0 into repeat, KEY1 joins -> INIT and locked.
        do_reset();
        switches = 10'd0;
        wait_cycles(10);
        c = cyc;
        push(16'h0101, c + 7);
        push(16'h0102, c + 27);
        push(16'h0103, c + 32);
        push(16'h0104, c + 37);
        push(16'h0100, c + 42);
        keys_n[0] = 1'b0;
        wait_cycles(35);
        keys_n[1] = 1'b0;
        wait_cycles(15);
        check("t5_locked_value", value, INIT);
        keys_n[1] = 1'b1;
        wait_cycles(40);
        check("t5_one_released", value, INIT);
        keys_n[0] = 1'b1;
        wait_cycles(20);
        c = cyc;
        push(16'h0101, c + 7);
        press(0, 10);
        wait_cycles(20);
        check("t5_after_unlock", value, 16'h0101);

        // 6: build 0x0123, reset while repeating, key still held.
        do_reset();
        switches = 10'd1;
        wait_cycles(10);
        c = cyc; push(16'h0110, c + 7); press(0, 10); wait_cycles(10);
        c = cyc; push(16'h0120, c + 7); press(0, 10); wait_cycles(10);
        switches = 10'h3FC;
        wait_cycles(10);
        check("t6_switches_db", switches_db, 10'h3FC);
        check("t6_digit_sel",   digit_sel,   0);
        c = cyc;
        push(16'h0121, c + 7);
        push(16'h0122, c + 27);
        push(16'h0123, c + 32);
        push(16'h0101, c + 41);
        push(16'h0102, c + 61);
        push(16'h0103, c + 66);
        keys_n[0] = 1'b0;
        wait_cycles(33);
        check("t6_pre_reset", value, 16'h0123);
        do_reset();
        check("t6_rst_value",       value,       INIT);
        check("t6_rst_value_upd",   value_upd,   0);
        check("t6_rst_switches_db", switches_db, 0);
        wait_cycles(29);
        keys_n[0] = 1'b1;
        wait_cycles(20);
        check("t6_value", value, 16'h0103);

        wait_cycles(10);
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keyunit.md
Name: keyunit

Overview:
- Input-side counterpart of the LED/hex display unit: turns raw board push-buttons and slide switches into a clean 16-bit setpoint `value` for the display/PWM path.
- Synchronises and debounces all inputs.
- KEY0 increments and KEY1 decrements the hex digit selected by switches[1:0], with hold-to-auto-repeat.
- Pressing both keys restores INIT_VALUE.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable synchronised cycles required before a debounced input changes (min 1)
HOLD_CYCLES, 25000000, cycles a single key must stay pressed after the first step before auto-repeat starts (min 1)
REPEAT_CYCLES, 5000000, cycles between auto-repeat steps (min 1)
INIT_VALUE, 16'h0000, value after reset and after a both-keys press

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
keys_n  input  2  raw push-buttons, active-low; [0]=increment, [1]=decrement
switches  input  10  raw slide switches
switches_db  output  10  synchronised, debounced switches
value  output  16  current setpoint
value_upd  output  1  one-cycle strobe, high in the cycle value shows a changed result
digit_sel  output  2  = switches_db[1:0]; selected hex digit, for display highlighting

Behaviour:
- Interface (already decided): one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values:
  - value=INIT_VALUE, value_upd=0, switches_db=0, digit_sel=0.
  - Debounced keys = released; FSM=IDLE; all counters=0; sync flops=released/0.
- Synchronisation: 2-flop synchroniser on every key and switch. Keys are inverted after sync (pressed=1).
- Debounce, per input, independent counter:
  - While the sync input equals the debounced state, the counter is 0.
  - While they differ, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the inputs still differ, the debounced state takes the sync value next edge and the counter clears.
  - Any mismatch gap before that clears the counter.
- Latency:
  - Clean raw edge to debounced change: 2+DEBOUNCE_CYCLES cycles.
  - Debounced press to value/value_upd: +1 cycle.
- Step size:
  - step = 16'h1 << (4*digit_sel).
  - Inc: value+step, saturating at 16'hFFFF.
  - Dec: value-step, saturating at 16'h0000.
  - Arithmetic is done in 17 bits and clamped.
- digit_sel is sampled at each step. Changing switches mid-hold changes the step of later repeats.
- FSM states: IDLE, WAIT_HOLD, REPEAT, LOCKED.
  - IDLE:
    - Exactly one debounced key rising: apply its step, clear counter, go to WAIT_HOLD.
    - Both keys pressed in the same cycle: go to LOCKED.
  - WAIT_HOLD:
    - Active key released: go to IDLE.
    - Counter reaches HOLD_CYCLES-1: apply step, clear counter, go to REPEAT.
  - REPEAT:
    - Active key released: go to IDLE.
    - Each REPEAT_CYCLES cycles: apply step.
  - Any state except LOCKED, both keys debounced pressed: value<=INIT_VALUE, go to LOCKED. This overrides any step due in that cycle.
  - LOCKED: no steps; stays until both keys are released, then goes to IDLE. Releasing one key does not resume stepping.
- value_upd: high exactly in cycles where the registered value differs from its previous value. A saturated step (no change) gives no strobe.
- Reset mid-operation: asserting reset in any state gives reset values on the next edge. No step is applied in that cycle.

Optional Feature:
- Macro: KEYUNIT_WRAP_EN.
- Defined: inc/dec wrap modulo 2^16 (16'hFFFF+1 -> 16'h0000, 0-step -> 16'h10000-step), so value_upd pulses on every step.
- Undefined: saturate as specified above.

Test Plan:
Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5, INIT_VALUE=16'h0100.
1. Reset, switches=0, pulse keys_n[0] low for 10 cycles -> single step; value=16'h0101, one value_upd pulse, 7 cycles after the falling edge (2+4+1).
2. Glitch keys_n[0] low 3 cycles, high 1, low 3 -> no debounced press; value stays 16'h0100, value_upd never asserted.
3. switches[1:0]=2'd2, hold keys_n[1] low 60 cycles -> steps at press, +20, then every 5 cycles.
   - Value sequence 0x0100 -> 0x0000 (-0x100, so exactly one value_upd).
   - Later dec steps saturate at 0x0000 with no further value_upd.
   - With KEYUNIT_WRAP_EN: 0x0000 -> 0xFF00 -> 0xFE00 ...
4. switches[1:0]=3 from value 16'hF100, press KEY0 -> 16'hFFFF (saturated), one value_upd.
   - With KEYUNIT_WRAP_EN: 16'h0100.
5. Hold KEY0 into REPEAT, then press KEY1 -> value=16'h0100 once debounced, state LOCKED.
   - Release KEY1 only: no further steps. Release both: IDLE.
   - New KEY0 press steps normally.
6. Assert reset for 1 cycle while in REPEAT with value=16'h0123 -> next edge value=16'h0100, value_upd=0, switches_db=0.
   - Key still held after reset is re-debounced, then starts a fresh WAIT_HOLD.
